csc_stream_encoder: RTL and testbench
=====================================

# csc_stream_encoder

Parametrised column-major compressed-sparse-column encoder for iact/weight tiles headed to GLB SRAM banks. It accepts a dense matrix stream one element per handshake, column by column, and emits two independently back-pressured streams: data words {value, row index} for every non-zero, and one address word per column. Each stream ends with a zero terminator. Unlike the fixed 8-bit/5-bit first generation, it has full ready/valid backpressure on all three ports, selectable empty-column encoding, a dedicated bank-clear sequence, and error flags.

## Interface
- DATA_WIDTH, 8, signed element width
- COUNT_WIDTH, 4, row-index field width in data word
- ADDR_WIDTH, 7, address word width; all-ones is reserved as the empty-column sentinel
- DIM_WIDTH, 5, width of matrix_height / matrix_width
- FIFO_DEPTH, 4, entries per output FIFO (power of two, ≥2)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- matrix_height  in  DIM_WIDTH  rows per column; sampled at start of matrix
- matrix_width  in  DIM_WIDTH  columns per matrix; sampled at start of matrix
- zero_col_mode  in  1  0: empty column emits sentinel (all ones); 1: empty column repeats cumulative pointer; sampled at start
- clear_iact_SRAM  in  1  level request for bank-clear sequence; honoured only in IDLE
- data_in_valid / data_in_ready  in / out  1 / 1  input handshake
- data_in  in  DATA_WIDTH  signed dense element
- data_out_valid / data_out_ready  out / in  1 / 1
- data_out  out  DATA_WIDTH+COUNT_WIDTH  {value, row index}
- address_out_valid / address_out_ready  out / in  1 / 1
- address_out  out  ADDR_WIDTH  column end pointer
- one_vector_done  out  1  one-cycle pulse when the address terminator handshakes
- busy  out  1  state ≠ IDLE
- cfg_error  out  1  sticky; cleared by reset or by the next accepted start
- addr_overflow  out  1  sticky; cleared by reset or by the next accepted start

## Operation
- States: IDLE, RUN, TERM, CLEAR.
- IDLE→RUN on the first accepted element, which is accepted in IDLE and processed as row 0, column 0. That cycle latches the config and zeroes row, column, and nz_count.
- Start is refused and cfg_error is set if any of the following hold: height=0, width=0, or height > 2^COUNT_WIDTH. data_in_ready stays 0 in that case while clear_iact_SRAM=0.
- data_in_ready = (IDLE or RUN) & !clear_iact_SRAM & data FIFO not full & address FIFO not full.
- Per accepted element:
  - non-zero: push {data_in, row} to the data FIFO and increment nz_count;
  - zero: no data push.
  - Row increments and wraps at height-1.
- Column end (row = height-1 accepted): push an address word.
  - If the column has ≥1 non-zero, the word is the cumulative nz_count including this element.
  - If the column is empty, the word is all-ones (mode 0) or the unchanged nz_count (mode 1).
  - A non-zero final element pushes its data word and the address word in the same cycle.
- Last element of the last column accepted → TERM. TERM pushes data terminator 0 and address terminator 0, each as soon as its FIFO has space, then returns to IDLE.
- nz_count saturates at 2^ADDR_WIDTH − 2. A non-zero that would exceed this sets addr_overflow and is dropped (no data push). Column pointers then report the saturated value.
- CLEAR (IDLE & clear_iact_SRAM):
  - flush both FIFOs;
  - present address_out=0 / data_out=0 with valid=1 until each has handshaked once;
  - return to IDLE.
  - The request must be deasserted before a new clear is taken.
- Asynchronous reset in any state:
  - state=IDLE, counters 0, FIFOs empty;
  - all valids 0, data_in_ready 0 during reset;
  - one_vector_done 0, busy 0, cfg_error 0, addr_overflow 0.

## Timing
- A push in cycle t produces valid output at t+1 when the FIFO was empty (registered FIFO, no bypass).
- Sustained throughput is 1 element/cycle while both output readies are held high.
- Output streams are independent: a stall on one blocks input only once that FIFO is full.
- one_vector_done asserts in the same cycle as the terminator's address_out_valid & address_out_ready. It is never asserted for CLEAR beats.
- The first TERM push occurs the cycle after the last input is accepted. The earliest return to IDLE is 1 cycle after that if both FIFOs have space.
- Simultaneous data_in_valid and clear_iact_SRAM in IDLE: the clear wins and the element is not accepted.

## Test plan
- Matrix 3×2, column-major input 0,5,0, 0,0,−3, both readies high, mode 0 → data {5,1},{−3,2},{0,0}; addresses 1,2,0; one_vector_done pulses once.
- Matrix 2×3, columns (0,0),(7,0),(0,0):
  - mode 0 → addresses 127,1,127,0;
  - mode 1 → addresses 0,1,1,0;
  - data {7,0},{0,0} in both modes.
- Dense 4×4, all non-zero, address_out_ready low for 20 cycles → input stalls once the address FIFO is full. After release: data rows 0..3 repeated per column, addresses 4,8,12,16,0, no loss or duplication.
- Height 17 with COUNT_WIDTH=4 → cfg_error=1, data_in_ready=0. A subsequent valid 2×2 start clears cfg_error and encodes normally.
- 16×16 all non-zero (256 > 126) → addr_overflow=1, exactly 126 data words plus terminator, column pointers saturate at 126.
- Assert reset mid-RUN with outputs pending → all valids 0 immediately. Next: clear_iact_SRAM for 3 cycles → exactly one zero beat on each output, busy returns to 0.

Source files
------------

// File: rtl/csc_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : csc_stream_encoder
//  Description : Column-major compressed-sparse-column encoder. Consumes a
//                dense matrix one element per handshake and emits a data
//                stream of {value, row} words and an address stream of
//                per-column end pointers, each ending with a zero terminator.
//  Revision    : 1.0 - initial release
// ============================================================================
module csc_stream_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4,
    parameter int ADDR_WIDTH  = 7,
    parameter int DIM_WIDTH   = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DIM_WIDTH-1:0]              matrix_height,
    input  logic [DIM_WIDTH-1:0]              matrix_width,
    input  logic                              zero_col_mode,
    input  logic                              clear_iact_SRAM,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    output logic [DATA_WIDTH+COUNT_WIDTH-1:0] data_out,
    output logic                              address_out_valid,
    input  logic                              address_out_ready,
    output logic [ADDR_WIDTH-1:0]             address_out,
    output logic                              one_vector_done,
    output logic                              busy,
    output logic                              cfg_error,
    output logic                              addr_overflow
);

    localparam int c_DW = DATA_WIDTH + COUNT_WIDTH;
    // Address FIFO entries carry a terminator tag above the pointer, since a
    // legitimate pointer can also be zero in repeat-pointer mode.
    localparam int c_AW = ADDR_WIDTH + 1;
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam logic [c_PW:0]           c_FIFO_FULL = FIFO_DEPTH[c_PW:0];
    localparam logic [ADDR_WIDTH-1:0]   c_NZ_MAX    = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0]   c_SENTINEL  = {ADDR_WIDTH{1'b1}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_TERM  = 2'd2;
    localparam logic [1:0] c_ST_CLEAR = 2'd3;

    logic [1:0]            r_state, w_state_next;
    logic [DIM_WIDTH-1:0]  r_height, r_width, r_row, r_col;
    logic                  r_mode, r_col_nz;
    logic [ADDR_WIDTH-1:0] r_nz;
    logic                  r_cfg_error, r_addr_ovf;
    logic                  r_term_ddone, r_term_adone, r_clr_ddone, r_clr_adone;
    logic                  r_clr_armed;

    // Output FIFOs
    logic [c_DW-1:0]       r_dmem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_amem [FIFO_DEPTH];
    logic [c_PW-1:0]       r_dwr, r_drd, r_awr, r_ard;
    logic [c_PW:0]         r_dcnt, r_acnt;

    // The first element is processed in IDLE against the live configuration.
    logic                  w_idle, w_cfg_ok, w_accept, w_nonzero, w_last_row, w_last_col;
    logic [DIM_WIDTH-1:0]  w_height, w_width, w_row, w_col;
    logic                  w_mode, w_col_nz, w_col_nz_next;
    logic [ADDR_WIDTH-1:0] w_nz, w_nz_next, w_col_ptr;
    logic                  w_elem_dpush, w_elem_apush, w_term_dpush, w_term_apush;
    logic                  w_dpush, w_apush, w_dpop, w_apop, w_flush;
    logic                  w_dfull, w_afull, w_dempty, w_aempty, w_start_clear;
    logic [c_DW-1:0]       w_dword;
    logic [c_AW-1:0]       w_aword;

    assign w_idle        = (r_state == c_ST_IDLE);
    assign w_cfg_ok      = (matrix_height != '0) && (matrix_width != '0) &&
                           (32'(matrix_height) <= (32'd1 << COUNT_WIDTH));
    assign w_height      = w_idle ? matrix_height : r_height;
    assign w_width       = w_idle ? matrix_width  : r_width;
    assign w_mode        = w_idle ? zero_col_mode : r_mode;
    assign w_row         = w_idle ? '0 : r_row;
    assign w_col         = w_idle ? '0 : r_col;
    assign w_nz          = w_idle ? '0 : r_nz;
    assign w_col_nz      = w_idle ? 1'b0 : r_col_nz;

    assign w_dfull       = (r_dcnt == c_FIFO_FULL);
    assign w_afull       = (r_acnt == c_FIFO_FULL);
    assign w_dempty      = (r_dcnt == '0);
    assign w_aempty      = (r_acnt == '0);

    assign w_accept      = data_in_valid && data_in_ready;
    assign w_nonzero     = (data_in != '0);
    assign w_last_row    = (w_row == w_height - DIM_WIDTH'(1));
    assign w_last_col    = (w_col == w_width - DIM_WIDTH'(1));
    assign w_elem_dpush  = w_accept && w_nonzero && (w_nz != c_NZ_MAX);
    assign w_nz_next     = w_nz + ADDR_WIDTH'(w_elem_dpush);
    assign w_col_nz_next = w_col_nz || w_nonzero;
    assign w_elem_apush  = w_accept && w_last_row;
    assign w_col_ptr     = (w_col_nz_next || w_mode) ? w_nz_next : c_SENTINEL;

    assign w_term_dpush  = (r_state == c_ST_TERM) && !r_term_ddone && !w_dfull;
    assign w_term_apush  = (r_state == c_ST_TERM) && !r_term_adone && !w_afull;

    assign w_dpush       = w_elem_dpush || w_term_dpush;
    assign w_apush       = w_elem_apush || w_term_apush;
    assign w_dword       = w_term_dpush ? '0 : {data_in, COUNT_WIDTH'(w_row)};
    assign w_aword       = w_term_apush ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, w_col_ptr};

    assign w_dpop        = (r_state != c_ST_CLEAR) && !w_dempty && data_out_ready;
    assign w_apop        = (r_state != c_ST_CLEAR) && !w_aempty && address_out_ready;

    // A held clear request is taken once; it must drop before re-arming.
    assign w_start_clear = w_idle && clear_iact_SRAM && r_clr_armed;
    assign w_flush       = w_start_clear;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_clear)
                    w_state_next = c_ST_CLEAR;
                else if (w_accept)
                    w_state_next = (w_last_row && w_last_col) ? c_ST_TERM : c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_accept && w_last_row && w_last_col)
                    w_state_next = c_ST_TERM;
            end
            c_ST_TERM: begin
                if ((r_term_ddone || w_term_dpush) && (r_term_adone || w_term_apush))
                    w_state_next = c_ST_IDLE;
            end
            default: begin
                if ((r_clr_ddone || data_out_ready) && (r_clr_adone || address_out_ready))
                    w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Output logic: FIFO heads normally, forced zero beats during CLEAR
    always_comb begin
        data_in_ready     = !reset && !clear_iact_SRAM && !w_dfull && !w_afull &&
                            ((w_idle && w_cfg_ok) || (r_state == c_ST_RUN));
        busy              = !w_idle;
        data_out_valid    = !w_dempty;
        data_out          = r_dmem[r_drd];
        address_out_valid = !w_aempty;
        address_out       = r_amem[r_ard][ADDR_WIDTH-1:0];
        one_vector_done   = !w_aempty && address_out_ready && r_amem[r_ard][ADDR_WIDTH];
        if (r_state == c_ST_CLEAR) begin
            data_out_valid    = !r_clr_ddone;
            data_out          = '0;
            address_out_valid = !r_clr_adone;
            address_out       = '0;
            one_vector_done   = 1'b0;
        end
        cfg_error         = r_cfg_error;
        addr_overflow     = r_addr_ovf;
    end

    // Matrix walk counters, latched configuration, sticky flags, sequence flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_height     <= '0;
            r_width      <= '0;
            r_mode       <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_nz         <= '0;
            r_col_nz     <= 1'b0;
            r_cfg_error  <= 1'b0;
            r_addr_ovf   <= 1'b0;
            r_term_ddone <= 1'b0;
            r_term_adone <= 1'b0;
            r_clr_ddone  <= 1'b0;
            r_clr_adone  <= 1'b0;
            r_clr_armed  <= 1'b1;
        end else begin
            if (w_idle && w_accept) begin
                r_height    <= matrix_height;
                r_width     <= matrix_width;
                r_mode      <= zero_col_mode;
                r_cfg_error <= 1'b0;
                r_addr_ovf  <= 1'b0;
            end else if (w_idle && data_in_valid && !clear_iact_SRAM && !w_cfg_ok) begin
                r_cfg_error <= 1'b1;
            end
            if (w_accept) begin
                r_nz     <= w_nz_next;
                r_row    <= w_last_row ? '0 : w_row + DIM_WIDTH'(1);
                r_col    <= w_last_row ? w_col + DIM_WIDTH'(1) : w_col;
                r_col_nz <= w_last_row ? 1'b0 : w_col_nz_next;
                if (w_nonzero && (w_nz == c_NZ_MAX))
                    r_addr_ovf <= 1'b1;
            end
            r_term_ddone <= (r_state == c_ST_TERM) && (r_term_ddone || w_term_dpush);
            r_term_adone <= (r_state == c_ST_TERM) && (r_term_adone || w_term_apush);
            r_clr_ddone  <= (r_state == c_ST_CLEAR) && (r_clr_ddone || data_out_ready);
            r_clr_adone  <= (r_state == c_ST_CLEAR) && (r_clr_adone || address_out_ready);
            if (w_start_clear)
                r_clr_armed <= 1'b0;
            else if (!clear_iact_SRAM)
                r_clr_armed <= 1'b1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dwr  <= '0;
            r_drd  <= '0;
            r_dcnt <= '0;
            r_awr  <= '0;
            r_ard  <= '0;
            r_acnt <= '0;
        end else if (w_flush) begin
            r_dwr  <= '0;
            r_drd  <= '0;
            r_dcnt <= '0;
            r_awr  <= '0;
            r_ard  <= '0;
            r_acnt <= '0;
        end else begin
            if (w_dpush) r_dwr <= r_dwr + c_PW'(1);
            if (w_dpop)  r_drd <= r_drd + c_PW'(1);
            if (w_apush) r_awr <= r_awr + c_PW'(1);
            if (w_apop)  r_ard <= r_ard + c_PW'(1);
            r_dcnt <= r_dcnt + (c_PW+1)'(w_dpush) - (c_PW+1)'(w_dpop);
            r_acnt <= r_acnt + (c_PW+1)'(w_apush) - (c_PW+1)'(w_apop);
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (w_dpush) r_dmem[r_dwr] <= w_dword;
        if (w_apush) r_amem[r_awr] <= w_aword;
    end

endmodule
`default_nettype wire

// File: tb/tb_csc_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csc_stream_encoder
//  Description : Scoreboard bench for csc_stream_encoder. A reference model
//                queues expected data/address words per matrix; a monitor
//                pops and compares them on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csc_stream_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  matrix_height, matrix_width;
    logic        zero_col_mode, clear_iact_SRAM;
    logic        data_in_valid, data_in_ready;
    logic [7:0]  data_in;
    logic        data_out_valid, data_out_ready;
    logic [11:0] data_out;
    logic        address_out_valid, address_out_ready;
    logic [6:0]  address_out;
    logic        one_vector_done, busy, cfg_error, addr_overflow;

    int n_vec = 0;
    int n_err = 0;
    int ovd_cnt = 0;
    int acc_cnt = 0;
    int stim[$];
    logic [11:0] exp_data[$];
    logic [7:0]  exp_addr[$];   // {terminator tag, pointer}

    csc_stream_encoder dut (
        .clock(clock), .reset(reset),
        .matrix_height(matrix_height), .matrix_width(matrix_width),
        .zero_col_mode(zero_col_mode), .clear_iact_SRAM(clear_iact_SRAM),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready), .data_in(data_in),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .data_out(data_out),
        .address_out_valid(address_out_valid), .address_out_ready(address_out_ready),
        .address_out(address_out), .one_vector_done(one_vector_done), .busy(busy),
        .cfg_error(cfg_error), .addr_overflow(addr_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Output monitor: every handshake is checked against the scoreboard
    always @(negedge clock) begin
        logic [11:0] ed;
        logic [7:0]  ea;
        if (one_vector_done) ovd_cnt++;
        if (data_in_valid && data_in_ready) acc_cnt++;
        if (data_out_valid && data_out_ready) begin
            if (exp_data.size() == 0) chk("data_extra_beat", 32'(data_out_valid), 0);
            else begin
                ed = exp_data.pop_front();
                chk("data_word", 32'(data_out), 32'(ed));
            end
        end
        if (address_out_valid && address_out_ready) begin
            if (exp_addr.size() == 0) chk("addr_extra_beat", 32'(address_out_valid), 0);
            else begin
                ea = exp_addr.pop_front();
                chk("addr_word", 32'(address_out), 32'(ea[6:0]));
                chk("ovd_on_addr", 32'(one_vector_done), 32'(ea[7]));
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (exp_data.size() == 0 && exp_addr.size() == 0) break;
        end
        chk("drain_pending", 32'(exp_data.size() + exp_addr.size()), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Model the encoding of stim, queue the results, then drive the elements
    task automatic run_matrix(input int h, input int w, input bit mode);
        int  nz;
        int  ovd0;
        int  waits;
        int  v;
        bit  colnz;
        bit  got;
        nz   = 0;
        ovd0 = ovd_cnt;
        for (int c = 0; c < w; c++) begin
            colnz = 0;
            for (int r = 0; r < h; r++) begin
                v = stim[c*h + r];
                if (v != 0) begin
                    colnz = 1;
                    if (nz < 126) begin
                        exp_data.push_back({8'(v), 4'(r)});
                        nz++;
                    end
                end
            end
            exp_addr.push_back((colnz || mode) ? {1'b0, 7'(nz)} : 8'h7F);
        end
        exp_data.push_back(12'h000);
        exp_addr.push_back(8'h80);
        matrix_height = 5'(h);
        matrix_width  = 5'(w);
        zero_col_mode = mode;
        for (int i = 0; i < h*w; i++) begin
            data_in       = 8'(stim[i]);
            data_in_valid = 1'b1;
            got   = 0;
            waits = 0;
            while (!got && waits < 300) begin
                @(negedge clock);
                got = data_in_ready;
                @(posedge clock);
                #1;
                waits++;
            end
            if (!got) begin
                chk("accept_timeout", 32'(data_in_ready), 1);
                break;
            end
        end
        data_in_valid = 1'b0;
        wait_drain(400);
        chk("ovd_pulses", 32'(ovd_cnt - ovd0), 1);
        chk("busy_after", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovd0;
        reset = 1'b1;
        matrix_height = 5'd3; matrix_width = 5'd2; zero_col_mode = 1'b0;
        clear_iact_SRAM = 1'b0; data_in_valid = 1'b0; data_in = 8'd0;
        data_out_ready = 1'b1; address_out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_data_valid", 32'(data_out_valid), 0);
        chk("rst_addr_valid", 32'(address_out_valid), 0);
        chk("rst_in_ready", 32'(data_in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_error", 32'(cfg_error), 0);
        chk("rst_addr_ovf", 32'(addr_overflow), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic 3x2 sparse matrix
        stim = {0, 5, 0, 0, 0, -3};
        run_matrix(3, 2, 1'b0);

        // Empty columns in both encodings
        stim = {0, 0, 7, 0, 0, 0};
        run_matrix(2, 3, 1'b0);
        run_matrix(2, 3, 1'b1);

        // Dense 4x4 with the address stream stalled for 20 cycles
        stim = {};
        for (int i = 0; i < 16; i++) stim.push_back(i + 1);
        acc_cnt = 0;
        address_out_ready = 1'b0;
        fork
            run_matrix(4, 4, 1'b0);
            begin
                repeat (20) @(posedge clock);
                #1;
                chk("dense_accepts", 32'(acc_cnt), 16);
                chk("dense_busy_stalled", 32'(busy), 1);
                chk("dense_addr_head", 32'(address_out), 4);
                address_out_ready = 1'b1;
            end
        join

        // 2x6 dense: input must stall once the address FIFO holds 4 pointers
        stim = {};
        for (int i = 0; i < 12; i++) stim.push_back(-(i + 1));
        acc_cnt = 0;
        address_out_ready = 1'b0;
        fork
            run_matrix(2, 6, 1'b0);
            begin
                repeat (20) @(posedge clock);
                #1;
                chk("stall_accepts", 32'(acc_cnt), 8);
                chk("stall_in_ready", 32'(data_in_ready), 0);
                address_out_ready = 1'b1;
            end
        join

        // Illegal configurations are refused
        matrix_height = 5'd17; matrix_width = 5'd2;
        data_in = 8'd1; data_in_valid = 1'b1;
        @(negedge clock);
        chk("cfg17_in_ready", 32'(data_in_ready), 0);
        @(posedge clock); #1;
        chk("cfg17_error", 32'(cfg_error), 1);
        chk("cfg17_busy", 32'(busy), 0);
        matrix_height = 5'd0;
        @(negedge clock);
        chk("cfg0_in_ready", 32'(data_in_ready), 0);
        @(posedge clock); #1;
        data_in_valid = 1'b0;
        stim = {1, 0, 0, 2};
        run_matrix(2, 2, 1'b0);
        chk("cfg_error_cleared", 32'(cfg_error), 0);

        // Pointer saturation
        stim = {};
        for (int i = 0; i < 256; i++) stim.push_back(1);
        run_matrix(16, 16, 1'b0);
        chk("ovf_set", 32'(addr_overflow), 1);
        stim = {3, 0, 0, 0};
        run_matrix(2, 2, 1'b1);
        chk("ovf_cleared", 32'(addr_overflow), 0);

        // Reset while outputs are pending
        data_out_ready = 1'b0; address_out_ready = 1'b0;
        matrix_height = 5'd3; matrix_width = 5'd2;
        data_in = 8'd9; data_in_valid = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        @(negedge clock);
        chk("pend_data_valid", 32'(data_out_valid), 1);
        chk("pend_addr_valid", 32'(address_out_valid), 1);
        chk("pend_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_data_valid", 32'(data_out_valid), 0);
        chk("mid_rst_addr_valid", 32'(address_out_valid), 0);
        chk("mid_rst_in_ready", 32'(data_in_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        exp_data.delete();
        exp_addr.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        data_out_ready = 1'b1; address_out_ready = 1'b1;
        @(posedge clock); #1;

        // Clear held for 3 cycles alongside a valid element: one zero beat each
        ovd0 = ovd_cnt;
        exp_data.push_back(12'h000);
        exp_addr.push_back(8'h00);
        matrix_height = 5'd2; matrix_width = 5'd2;
        data_in = 8'd5; data_in_valid = 1'b1;
        clear_iact_SRAM = 1'b1;
        @(negedge clock);
        chk("clr_in_ready", 32'(data_in_ready), 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("clr_busy", 32'(busy), 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear_iact_SRAM = 1'b0;
        data_in_valid = 1'b0;
        wait_drain(50);
        repeat (5) @(posedge clock);
        #1;
        chk("clr_busy_after", 32'(busy), 0);
        chk("clr_no_ovd", 32'(ovd_cnt - ovd0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
